// File: rtl/instruction_loader.sv
// instruction_loader: gathers bytes from the debug UART into 32-bit words and
// hands each finished word to the program memory's debug write port as a
// one-cycle strobe. A load begins on a command from the debug unit and ends on
// the HALT word or when memory runs out of space.
module instruction_loader #(
  parameter int                            SIZE_REGISTER_INST = 32,
  parameter int                            SIZE_MEMORY        = 10,
  parameter int                            SIZE_BYTE          = 8,
  parameter logic [SIZE_REGISTER_INST-1:0] HALT_INST          = 32'hFFFF_FFFF
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_load_start,
  input  logic [SIZE_BYTE-1:0]          i_rx_data,
  input  logic                          i_rx_done,
  output logic [SIZE_REGISTER_INST-1:0] o_instruction,
  output logic                          o_write_en,
  output logic [SIZE_MEMORY:0]          o_inst_count,
  output logic                          o_busy,
  output logic                          o_load_done,
  output logic                          o_mem_full
);

  localparam int W = SIZE_REGISTER_INST;
  localparam int B = SIZE_BYTE;

  // Count value just before the last free slot is used; writing at this count
  // fills memory.
  localparam logic [SIZE_MEMORY:0] LAST_SLOT = {1'b0, {SIZE_MEMORY{1'b1}}};

  typedef enum logic [1:0] {IDLE, RECEIVE, WRITE, DONE} state_t;

  state_t        state;
  logic [1:0]    byte_idx;
  logic [W-1:0]  asm_reg;

  // Loader FSM. All outputs are registered here, so nothing is combinational
  // from inputs to outputs. The finished word is copied into o_instruction on
  // entry to WRITE, so bytes of the next word arriving during WRITE cannot
  // disturb the word being written.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state         <= IDLE;
      byte_idx      <= 2'd0;
      asm_reg       <= '0;
      o_instruction <= '0;
      o_write_en    <= 1'b0;
      o_inst_count  <= '0;
      o_busy        <= 1'b0;
      o_load_done   <= 1'b0;
      o_mem_full    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_load_start) begin
            state    <= RECEIVE;
            byte_idx <= 2'd0;
            o_busy   <= 1'b1;
          end
        end

        RECEIVE: begin
          if (i_rx_done) begin
            // Big-endian: first byte lands in the top lane.
            case (byte_idx)
              2'd0: asm_reg[4*B-1 -: B] <= i_rx_data;
              2'd1: asm_reg[3*B-1 -: B] <= i_rx_data;
              2'd2: asm_reg[2*B-1 -: B] <= i_rx_data;
              default: asm_reg[B-1 -: B] <= i_rx_data;
            endcase
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              o_instruction <= {asm_reg[W-1:B], i_rx_data};
              o_write_en    <= 1'b1;
              state         <= WRITE;
            end
          end
        end

        WRITE: begin
          o_write_en   <= 1'b0;
          o_inst_count <= o_inst_count + 1'b1;
          if (o_instruction == HALT_INST) begin
            state       <= DONE;
            o_busy      <= 1'b0;
            o_load_done <= 1'b1;
          end else if (o_inst_count == LAST_SLOT) begin
            state       <= DONE;
            o_busy      <= 1'b0;
            o_load_done <= 1'b1;
            o_mem_full  <= 1'b1;
          end else begin
            state <= RECEIVE;
            // A byte arriving in the strobe cycle starts the next word.
            if (i_rx_done) begin
              asm_reg[4*B-1 -: B] <= i_rx_data;
              byte_idx            <= 2'd1;
            end
          end
        end

        DONE: begin
          // Terminal until reset; the memory's write pointer also needs reset.
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_loader.sv
// tb_instruction_loader: directed vectors against two loaders sharing one
// stimulus stream -- a full-size one and a 4-word one for the capacity case.
// Each loader feeds a small program memory model with its own write pointer.
module tb_instruction_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_start = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_done = 1'b0;

  logic [31:0] instr_big,  instr_sml;
  logic        we_big,     we_sml;
  logic [10:0] cnt_big;
  logic [2:0]  cnt_sml;
  logic        busy_big,   busy_sml;
  logic        done_big,   done_sml;
  logic        full_big,   full_sml;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  instruction_loader u_big (
    .i_clk(clk), .i_reset(rst_n), .i_load_start(load_start),
    .i_rx_data(rx_data), .i_rx_done(rx_done),
    .o_instruction(instr_big), .o_write_en(we_big), .o_inst_count(cnt_big),
    .o_busy(busy_big), .o_load_done(done_big), .o_mem_full(full_big)
  );

  instruction_loader #(.SIZE_MEMORY(2)) u_sml (
    .i_clk(clk), .i_reset(rst_n), .i_load_start(load_start),
    .i_rx_data(rx_data), .i_rx_done(rx_done),
    .o_instruction(instr_sml), .o_write_en(we_sml), .o_inst_count(cnt_sml),
    .o_busy(busy_sml), .o_load_done(done_sml), .o_mem_full(full_sml)
  );

  // Program memory models: write at pointer on each strobe, pointer cleared by reset.
  logic [31:0] mem_big [0:63];
  logic [31:0] mem_sml [0:7];
  int wp_big, wp_sml;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) wp_big <= 0;
    else if (we_big) begin
      if (wp_big < 64) mem_big[wp_big] <= instr_big;
      wp_big <= wp_big + 1;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) wp_sml <= 0;
    else if (we_sml) begin
      if (wp_sml < 8) mem_sml[wp_sml] <= instr_sml;
      wp_sml <= wp_sml + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk); rx_data = b; rx_done = 1'b1;
    @(negedge clk); rx_done = 1'b0;
  endtask

  // Returns on the negedge where the strobe for this word should be visible.
  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask

  task automatic pulse_start();
    @(negedge clk); load_start = 1'b1;
    @(negedge clk); load_start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_instr"}, instr_big, 32'h0);
    chk({tag, "_we"},    {31'b0, we_big}, 32'h0);
    chk({tag, "_cnt"},   {21'b0, cnt_big}, 32'h0);
    chk({tag, "_flags"}, {29'b0, busy_big, done_big, full_big}, 32'h0);
  endtask

  logic [31:0] prog [0:5];

  initial begin
    prog[0] = 32'h2001_0005; prog[1] = 32'h8C22_0004; prog[2] = 32'h0043_0820;
    prog[3] = 32'hAC01_0008; prog[4] = 32'h1000_FFFF; prog[5] = 32'hFFFF_FFFF;

    // Reset values
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;

    // Bytes before any load command are ignored
    send_word(32'h1234_5678);
    repeat (2) @(negedge clk);
    chk("idle_strobes", wp_big, 0);
    chk("idle_cnt", {21'b0, cnt_big}, 32'd0);
    chk("idle_busy", {31'b0, busy_big}, 32'd0);

    // First word: latency and data
    pulse_start();
    chk("busy_after_start", {31'b0, busy_big}, 32'd1);
    send_word(32'h2001_0005);
    chk("w0_we", {31'b0, we_big}, 32'd1);
    chk("w0_instr", instr_big, 32'h2001_0005);
    @(negedge clk);
    chk("w0_we_drop", {31'b0, we_big}, 32'd0);
    chk("w0_cnt", {21'b0, cnt_big}, 32'd1);
    chk("w0_busy", {31'b0, busy_big}, 32'd1);

    // Second word with a stray load command mid-word
    send_byte(8'h11); send_byte(8'h22);
    pulse_start();
    send_byte(8'h33); send_byte(8'h44);
    chk("w1_instr", instr_big, 32'h1122_3344);
    send_word(32'hDEAD_BEEF);
    chk("w2_instr", instr_big, 32'hDEAD_BEEF);
    send_word(32'hFFFF_FFFF);
    chk("halt_we", {31'b0, we_big}, 32'd1);
    chk("halt_instr", instr_big, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("halt_strobes", wp_big, 4);
    chk("halt_cnt", {21'b0, cnt_big}, 32'd4);
    chk("halt_flags", {29'b0, busy_big, done_big, full_big}, 32'b010);
    // 4-word loader: HALT lands in its last slot; HALT wins, not mem_full
    chk("sml_halt_flags", {29'b0, busy_sml, done_sml, full_sml}, 32'b010);
    chk("sml_halt_cnt", {29'b0, cnt_sml}, 32'd4);
    // Nothing more after DONE
    pulse_start();
    send_word(32'h0102_0304);
    repeat (2) @(negedge clk);
    chk("done_strobes", wp_big, 4);
    chk("done_cnt", {21'b0, cnt_big}, 32'd4);

    // Reset in the middle of a word
    do_reset();
    pulse_start();
    send_byte(8'h55); send_byte(8'h66);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midreset");
    @(negedge clk); rst_n = 1'b1;
    pulse_start();
    send_word(32'hAABB_CCDD);
    chk("post_reset_we", {31'b0, we_big}, 32'd1);
    chk("post_reset_instr", instr_big, 32'hAABB_CCDD);
    @(negedge clk);
    chk("post_reset_cnt", {21'b0, cnt_big}, 32'd1);

    // Back-to-back bytes into the 4-word loader until it fills
    do_reset();
    pulse_start();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); rx_data = 8'h10 + 8'(i); rx_done = 1'b1;
    end
    @(negedge clk); rx_done = 1'b0;
    repeat (2) @(negedge clk);
    chk("b2b_strobes", wp_sml, 4);
    chk("b2b_w0", mem_sml[0], 32'h1011_1213);
    chk("b2b_w1", mem_sml[1], 32'h1415_1617);
    chk("b2b_w2", mem_sml[2], 32'h1819_1A1B);
    chk("b2b_w3", mem_sml[3], 32'h1C1D_1E1F);
    chk("b2b_flags", {29'b0, busy_sml, done_sml, full_sml}, 32'b011);
    chk("b2b_cnt", {29'b0, cnt_sml}, 32'd4);
    chk("b2b_big_flags", {29'b0, busy_big, done_big, full_big}, 32'b100);
    chk("b2b_big_cnt", {21'b0, cnt_big}, 32'd4);
    send_word(32'h0000_0001);
    repeat (2) @(negedge clk);
    chk("full_no_more", wp_sml, 4);

    // Program load and read-back through the memory model
    do_reset();
    pulse_start();
    for (int k = 0; k < 6; k++) send_word(prog[k]);
    repeat (2) @(negedge clk);
    chk("prog_strobes", wp_big, 6);
    chk("prog_cnt", {21'b0, cnt_big}, 32'd6);
    chk("prog_done", {31'b0, done_big}, 32'd1);
    for (int a = 0; a <= 20; a += 4)
      chk($sformatf("mem_addr_%0d", a), mem_big[a/4], prog[a/4]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
